// File: rtl/serial_subtractor8bit.sv
// Bit-serial 8-bit subtractor: one full-subtractor cell, LSB first, 8 cycles.
// Define SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_subtractor8bit (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       busy,
  output logic       done,
  output logic [7:0] diff,
  output logic       borrow
`ifdef SUB_OVF_EN
  ,
  output logic       ovf
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       load;
  logic [7:0] a_sr;
  logic [7:0] b_sr;
  logic [7:0] diff_sr;
  logic [2:0] cnt;
  logic       br;
  logic       abit;
  logic       bbit;
  logic       d;
  logic       br_nxt;
  logic       last;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Both flags come straight from the state register.
  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  assign abit   = a_sr[0];
  assign bbit   = b_sr[0];
  assign d      = abit ^ bbit ^ br;
  assign br_nxt = (~abit & bbit) | (~(abit ^ bbit) & br);
  assign last   = (cnt == 3'd7);

  always_ff @(posedge clk) begin
    if (reset) begin
      a_sr    <= 8'h00;
      b_sr    <= 8'h00;
      diff_sr <= 8'h00;
      cnt     <= 3'd0;
      br      <= 1'b0;
    end else if (load) begin
      a_sr    <= a;
      b_sr    <= b;
      diff_sr <= 8'h00;
      cnt     <= 3'd0;
      br      <= 1'b0;
    end else if (state == SHIFT) begin
      a_sr    <= {1'b0, a_sr[7:1]};
      b_sr    <= {1'b0, b_sr[7:1]};
      diff_sr <= {d, diff_sr[7:1]};
      cnt     <= cnt + 3'd1;
      br      <= br_nxt;
    end
  end

  // Visible result changes only on the edge that enters DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      diff   <= 8'h00;
      borrow <= 1'b0;
    end else if (state == SHIFT && last) begin
      diff   <= {d, diff_sr[7:1]};
      borrow <= br_nxt;
    end
  end

`ifdef SUB_OVF_EN
  logic a_msb;
  logic b_msb;

  always_ff @(posedge clk) begin
    if (reset) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
    end else if (load) begin
      a_msb <= a[7];
      b_msb <= b[7];
      ovf   <= 1'b0;
    end else if (state == SHIFT && last) begin
      ovf   <= (a_msb != b_msb) && (d != a_msb);
    end
  end
`endif

endmodule

// File: tb/tb_serial_subtractor8bit.sv
// Self-checking bench for serial_subtractor8bit against an arithmetic model.
// Build with +define+SUB_OVF_EN to cover the ovf output as well.
module tb_serial_subtractor8bit;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       borrow;
`ifdef SUB_OVF_EN
  logic       ovf;
`endif

  int pass_cnt;
  int total;

  serial_subtractor8bit dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
`ifdef SUB_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] m_diff(input logic [7:0] x, input logic [7:0] y);
    int r;
    r = (int'(x) - int'(y) + 256) % 256;
    return r[7:0];
  endfunction

  function automatic logic m_borrow(input logic [7:0] x, input logic [7:0] y);
    return int'(x) < int'(y);
  endfunction

  function automatic logic m_ovf(input logic [7:0] x, input logic [7:0] y);
    int sx;
    int sy;
    int r;
    sx = (x >= 8'd128) ? int'(x) - 256 : int'(x);
    sy = (y >= 8'd128) ? int'(y) - 256 : int'(y);
    r  = sx - sy;
    return (r < -128) || (r > 127);
  endfunction

  function automatic logic get_ovf();
`ifdef SUB_OVF_EN
    return ovf;
`else
    return 1'b0;
`endif
  endfunction

  // Pulse start with operands, then scramble inputs and wait for done.
  task automatic do_op(input logic [7:0] x, input logic [7:0] y,
                       output logic [7:0] od, output logic obr,
                       output logic oov, output int lat, output int bcnt);
    @(negedge clk);
    a = x;
    b = y;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    lat  = 0;
    bcnt = 0;
    while (!done && lat < 20) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    od  = diff;
    obr = borrow;
    oov = get_ovf();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    a = 8'h00;
    b = 8'h00;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL reset_flags busy=%b done=%b required 0 0", busy, done);
    else pass_cnt++;
    total++;
    if (diff !== 8'h00 || borrow !== 1'b0)
      $display("FAIL reset_result diff=%h borrow=%b required 00 0", diff, borrow);
    else pass_cnt++;
    total++;
    if (get_ovf() !== 1'b0)
      $display("FAIL reset_ovf ovf=%b required 0", get_ovf());
    else pass_cnt++;
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL idle_after_reset busy=%b done=%b required 0 0", busy, done);
    else pass_cnt++;
  endtask

  task automatic check_op(input string nm, input logic [7:0] x, input logic [7:0] y);
    logic [7:0] od;
    logic       obr;
    logic       oov;
    int         lat;
    int         bcnt;
    do_op(x, y, od, obr, oov, lat, bcnt);
    total++;
    if (lat !== 8 || bcnt !== 8)
      $display("FAIL %s_timing a=%h b=%h latency=%0d busy=%0d required 8 8",
               nm, x, y, lat, bcnt);
    else pass_cnt++;
    total++;
    if (od !== m_diff(x, y) || obr !== m_borrow(x, y) || busy !== 1'b0)
      $display("FAIL %s_result a=%h b=%h diff=%h borrow=%b busy=%b required %h %b 0",
               nm, x, y, od, obr, busy, m_diff(x, y), m_borrow(x, y));
    else pass_cnt++;
`ifdef SUB_OVF_EN
    total++;
    if (oov !== m_ovf(x, y))
      $display("FAIL %s_ovf a=%h b=%h ovf=%b required %b", nm, x, y, oov, m_ovf(x, y));
    else pass_cnt++;
`endif
  endtask

  task automatic test_directed();
    check_op("d0503", 8'h05, 8'h03);
    check_op("d0305", 8'h03, 8'h05);
    check_op("d0000", 8'h00, 8'h00);
    check_op("dffff", 8'hFF, 8'hFF);
    check_op("d8001", 8'h80, 8'h01);
    check_op("d1020", 8'h10, 8'h20);
    check_op("d7f80", 8'h7F, 8'h80);
    check_op("d00ff", 8'h00, 8'hFF);
  endtask

  task automatic test_hold();
    logic [7:0] hd;
    logic       hb;
    check_op("hold", 8'h3C, 8'h5A);
    hd = diff;
    hb = borrow;
    repeat (4) @(negedge clk);
    total++;
    if (diff !== m_diff(8'h3C, 8'h5A) || borrow !== 1'b1 || done !== 1'b0)
      $display("FAIL hold diff=%h borrow=%b done=%b required %h 1 0",
               diff, borrow, done, m_diff(8'h3C, 8'h5A));
    else pass_cnt++;
    total++;
    if (diff !== hd || borrow !== hb)
      $display("FAIL hold_stable diff=%h borrow=%b required %h %b", diff, borrow, hd, hb);
    else pass_cnt++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      check_op("rand", 8'($urandom), 8'($urandom));
    end
  endtask

  task automatic test_start_ignored();
    int         ndone;
    logic [7:0] seen;
    logic [7:0] mid;
    logic       toggled;
    @(negedge clk);
    a = 8'h09;
    b = 8'h04;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mid = diff;
    toggled = 1'b0;
    ndone = 0;
    seen = 8'h00;
    for (int i = 0; i < 20; i++) begin
      if (i == 3) begin
        a = 8'h01;
        b = 8'h01;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (busy && diff !== mid) toggled = 1'b1;
      if (done) begin
        ndone++;
        seen = diff;
      end
      @(negedge clk);
    end
    total++;
    if (ndone !== 1 || seen !== 8'h05)
      $display("FAIL ignore_start done_count=%0d diff=%h required 1 05", ndone, seen);
    else pass_cnt++;
    total++;
    if (toggled !== 1'b0)
      $display("FAIL diff_toggle_in_shift saw=%b required 0", toggled);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int ndone;
    int last;
    int bad_gap;
    int bad_diff;
    int bad_busy;
    @(negedge clk);
    a = 8'h20;
    b = 8'h10;
    start = 1'b1;
    ndone = 0;
    last = -1;
    bad_gap = 0;
    bad_diff = 0;
    bad_busy = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (busy !== ~done) bad_busy++;
      if (done) begin
        ndone++;
        if (diff !== 8'h10) bad_diff++;
        if (last >= 0 && i - last != 9) bad_gap++;
        last = i;
      end
    end
    start = 1'b0;
    repeat (12) @(negedge clk);
    total++;
    if (ndone !== 5 || bad_gap !== 0)
      $display("FAIL b2b_rate dones=%0d bad_gaps=%0d required 5 0", ndone, bad_gap);
    else pass_cnt++;
    total++;
    if (bad_diff !== 0)
      $display("FAIL b2b_diff bad=%0d required 0", bad_diff);
    else pass_cnt++;
    total++;
    if (bad_busy !== 0)
      $display("FAIL b2b_busy bad=%0d required 0", bad_busy);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int ndone;
    @(negedge clk);
    a = 8'hA5;
    b = 8'h11;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h00 || borrow !== 1'b0)
      $display("FAIL mid_reset busy=%b done=%b diff=%h borrow=%b required 0 0 00 0",
               busy, done, diff, borrow);
    else pass_cnt++;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) ndone++;
      @(negedge clk);
    end
    total++;
    if (ndone !== 0)
      $display("FAIL mid_reset_quiet activity=%0d required 0", ndone);
    else pass_cnt++;
    check_op("post_reset", 8'h42, 8'h17);
  endtask

  initial begin
    pass_cnt = 0;
    total = 0;
    reset = 1'b1;
    start = 1'b0;
    a = 8'h00;
    b = 8'h00;
    test_reset();
    test_directed();
    test_hold();
    test_random();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
